name_rle_ctrl: RTL and testbench

NAME_RLE_CTRL -- requirements
Module: name_rle_ctrl

---
 rtl/name_rle_pkg.sv | 15 +
 rtl/name_rle_out_stage.sv | 47 ++++
 rtl/name_rle_ctrl.sv | 135 +++++++++++++
 tb/tb_name_rle_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/name_rle_pkg.sv
// name_rle_pkg: shared defaults, record field offsets and FSM states for the name run-length controller.
// Contents:
//    DEF_NAME_W / DEF_CNT_W  default read-name and run-count widths
//    REC_CNT_LSB             bit offset of the count field inside a record
//    rec_name_lsb()          bit offset of the name field (sits just above the count)
//    rle_state_e             controller states IDLE, RUN, FLUSH
package name_rle_pkg;
   localparam int DEF_NAME_W  = 128;
   localparam int DEF_CNT_W   = 32;
   localparam int REC_CNT_LSB = 0;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} rle_state_e;
   function automatic int rec_name_lsb(input int cnt_w);
      return REC_CNT_LSB + cnt_w;
   endfunction
endpackage

// File: rtl/name_rle_out_stage.sv
// name_rle_out_stage: single output register with valid/ready hold and same-cycle reload.
// Ports:
//    clk, reset_n   clock, asynchronous active-low reset
//    load_i         load rec_i/last_i into the register this cycle
//    rec_i, last_i  record and last flag to load
//    ready_i        downstream ready
//    valid_o        register holds a record
//    rec_o, last_o  held record and last flag
//    free_o         register can take a new record this cycle (empty or draining)
module name_rle_out_stage
#(
   parameter int W = 160
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] rec_i,
   input  logic         last_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] rec_o,
   output logic         last_o,
   output logic         free_o
);
   logic         valid_q, valid_d, last_q, last_d;
   logic [W-1:0] rec_q, rec_d;
   always_comb begin
      valid_d = load_i | (valid_q & ~ready_i);
      rec_d   = load_i ? rec_i : rec_q;
      last_d  = load_i ? last_i : last_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         rec_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rec_q   <= rec_d;
         last_q  <= last_d;
      end
   end
   assign valid_o = valid_q;
   assign rec_o   = rec_q;
   assign last_o  = last_q;
   assign free_o  = ~valid_q | ready_i;
endmodule

// File: rtl/name_rle_ctrl.sv
// name_rle_ctrl: collapses a stream of read names into {name, count} run records.
// Ports:
//    clk, reset_n                     clock, asynchronous active-low reset
//    in_valid/in_ready/in_name/in_last  input name stream (valid/ready)
//    out_valid/out_ready/out_record/out_last  output records {name, count}
//    busy                             FSM not IDLE
//    stat_names/stat_records          saturating counters, only when NAME_RLE_STATS_EN is defined
module name_rle_ctrl
   import name_rle_pkg::*;
#(
   parameter int NAME_W = DEF_NAME_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NAME_W-1:0]   in_name,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NAME_W+CNT_W-1:0] out_record,
   output logic                out_last,
   output logic                busy
`ifdef NAME_RLE_STATS_EN
   ,
   output logic [31:0]         stat_names,
   output logic [31:0]         stat_records
`endif
);
   localparam int NAME_LSB = rec_name_lsb(CNT_W);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   rle_state_e state_q, state_d;
   logic [NAME_W-1:0] cur_name_q, cur_name_d, pend_q, pend_d, ld_name;
   logic [CNT_W-1:0]  cnt_q, cnt_d, ld_cnt;
   logic [NAME_W+CNT_W-1:0] ld_rec;
   logic ld, ld_last, free, acc, match, sat;
   assign in_ready = (state_q != FLUSH) & free;
   assign acc      = in_valid & in_ready;
   assign match    = in_name == cur_name_q;
   assign sat      = cnt_q == {CNT_W{1'b1}};
   assign busy     = state_q != IDLE;
   assign ld_rec[NAME_LSB +: NAME_W]   = ld_name;
   assign ld_rec[REC_CNT_LSB +: CNT_W] = ld_cnt;
   always_comb begin
      state_d    = state_q;
      cur_name_d = cur_name_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      ld         = 1'b0;
      ld_name    = cur_name_q;
      ld_cnt     = cnt_q;
      ld_last    = 1'b0;
      case (state_q)
         IDLE: if (acc) begin
            cur_name_d = in_name;
            cnt_d      = ONE;
            if (in_last) begin
               ld      = 1'b1;
               ld_name = in_name;
               ld_cnt  = ONE;
               ld_last = 1'b1;
            end else state_d = RUN;
         end
         RUN: if (acc) begin
            if (match && !sat) begin
               if (in_last) begin
                  ld      = 1'b1;
                  ld_cnt  = cnt_q + ONE;
                  ld_last = 1'b1;
                  state_d = IDLE;
               end else cnt_d = cnt_q + ONE;
            end else begin
               // New name or saturated run: emit the current run, then either
               // park the final name for FLUSH or start a fresh run with it.
               ld = 1'b1;
               if (in_last) begin
                  pend_d  = in_name;
                  state_d = FLUSH;
               end else begin
                  cur_name_d = in_name;
                  cnt_d      = ONE;
               end
            end
         end
         FLUSH: if (free) begin
            ld      = 1'b1;
            ld_name = pend_q;
            ld_cnt  = ONE;
            ld_last = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cur_name_q <= '0;
         cnt_q      <= '0;
         pend_q     <= '0;
      end else begin
         state_q    <= state_d;
         cur_name_q <= cur_name_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
      end
   end
   name_rle_out_stage #(.W(NAME_W + CNT_W)) u_out (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (ld),
      .rec_i   (ld_rec),
      .last_i  (ld_last),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .rec_o   (out_record),
      .last_o  (out_last),
      .free_o  (free)
   );
`ifdef NAME_RLE_STATS_EN
   logic [31:0] stat_names_q, stat_records_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_names_q   <= '0;
         stat_records_q <= '0;
      end else begin
         if (acc && stat_names_q != '1) stat_names_q <= stat_names_q + 32'd1;
         if (out_valid && out_ready && stat_records_q != '1) stat_records_q <= stat_records_q + 32'd1;
      end
   end
   assign stat_names   = stat_names_q;
   assign stat_records = stat_records_q;
`endif
endmodule

// File: tb/tb_name_rle_ctrl.sv
// tb_name_rle_ctrl: directed and randomized checks of name_rle_ctrl against a run-length reference model.
module tb_name_rle_ctrl;
   localparam int NW = 16;
   localparam int CW = 4;
   localparam int MAXC = (1 << CW) - 1;
   typedef struct {
      logic [NW-1:0] name;
      logic [CW-1:0] cnt;
      logic          last;
   } rec_t;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [NW-1:0] in_name = '0;
   logic in_ready, out_valid, out_last, busy;
   logic [NW+CW-1:0] out_record;
`ifdef NAME_RLE_STATS_EN
   logic [31:0] stat_names, stat_records;
`endif
   int n_chk = 0, n_pass = 0, n_fail = 0;
   int mode = 0;
   rec_t exp_q[$];
   localparam logic [NW-1:0] A = 16'hA0A0, B = 16'hB1B1, C = 16'hC2C2, D = 16'hD3D3;

   name_rle_ctrl #(.NAME_W(NW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_name(in_name), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_record(out_record), .out_last(out_last),
      .busy(busy)
`ifdef NAME_RLE_STATS_EN
      , .stat_names(stat_names), .stat_records(stat_records)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain run-length encoding with runs capped at MAXC, final record flagged last.
   task automatic model_add(input logic [NW-1:0] ns[$]);
      rec_t r;
      logic [NW-1:0] cur;
      int cnt;
      cur = ns[0];
      cnt = 1;
      for (int i = 1; i < ns.size(); i++) begin
         if (ns[i] == cur && cnt < MAXC) cnt++;
         else begin
            r.name = cur; r.cnt = CW'(cnt); r.last = 1'b0;
            exp_q.push_back(r);
            cur = ns[i];
            cnt = 1;
         end
      end
      r.name = cur; r.cnt = CW'(cnt); r.last = 1'b1;
      exp_q.push_back(r);
   endtask

   task automatic push(input logic [NW-1:0] n, input logic l);
      int k;
      @(negedge clk);
      in_valid = 1'b1; in_name = n; in_last = l;
      for (k = 0; k < 100; k++) begin
         #1;
         if (in_ready) break;
         @(negedge clk);
      end
      chk("accept_wait", 64'(k < 100), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_valid", 64'(out_valid), 64'd0);
   endtask

   task automatic run_stream(input logic [NW-1:0] ns[$]);
      model_add(ns);
      for (int i = 0; i < ns.size(); i++) push(ns[i], i == ns.size() - 1);
      drain();
   endtask

   // Downstream: drives out_ready per mode, checks every transfer against the model queue
   // and that a stalled record stays put.
   logic stall_prev = 1'b0;
   logic [NW+CW:0] stall_val = '0;
   always begin
      rec_t e;
      @(negedge clk);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : ($urandom_range(0, 2) != 0);
      #2;
      if (!reset_n) stall_prev = 1'b0;
      else begin
         if (stall_prev) chk("hold_stable", 64'({out_last, out_record}), 64'(stall_val));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_record", 64'(out_record), 64'd0 - 64'd1);
            else begin
               e = exp_q.pop_front();
               chk("record", 64'(out_record), 64'({e.name, e.cnt}));
               chk("rec_last", 64'(out_last), 64'(e.last));
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_val = {out_last, out_record};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [NW-1:0] ns[$];
      logic [NW-1:0] prev;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_record", 64'(out_record), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset_n = 1'b1;

      ns = '{A, A, A, B};
      run_stream(ns);
`ifdef NAME_RLE_STATS_EN
      chk("stat_names", 64'(stat_names), 64'd4);
      chk("stat_records", 64'(stat_records), 64'd2);
`endif

      ns = '{A, A};
      model_add(ns);
      push(A, 1'b0);
      push(A, 1'b1);
      chk("aa_no_flush_busy", 64'(busy), 64'd0);
      chk("aa_valid", 64'(out_valid), 64'd1);
      chk("aa_last", 64'(out_last), 64'd1);
      chk("aa_record", 64'(out_record), 64'({A, 4'd2}));
      drain();

      ns = {};
      for (int i = 0; i < 17; i++) ns.push_back(A);
      run_stream(ns);

      mode = 1;
      ns = '{A, B, C, D};
      model_add(ns);
      push(A, 1'b0);
      push(B, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_rec", 64'(out_record), 64'({A, 4'd1}));
      end
      mode = 0;
      push(C, 1'b0);
      push(D, 1'b1);
      drain();

      mode = 1;
      push(A, 1'b0);
      push(A, 1'b0);
      push(B, 1'b0);
      @(negedge clk);
      #1;
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_record", 64'(out_record), 64'd0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      mode = 0;
      ns = '{B};
      run_stream(ns);

      mode = 2;
      for (int s = 0; s < 8; s++) begin
         ns = {};
         prev = A;
         for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 2))
                  0: prev = A;
                  1: prev = B;
                  default: prev = C;
               endcase
            end
            ns.push_back(prev);
         end
         run_stream(ns);
      end
      mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
